// File: rtl/ni_flit_injector.sv
// ni_flit_injector: transmit side of a credit-based router link.
// Tags packet beats with a flit type, inserts the destination into head and
// single flits, buffers them in a small FIFO and launches one flit per cycle
// while downstream credits remain. An empty FIFO is bypassed so a beat can
// reach the link on the cycle after it is accepted.
// Optional feature: define NI_INJ_CREDIT_ERR_EN to get a sticky credit
// overflow flag on err_credit_ovf (otherwise the flag is tied low).
module ni_flit_injector #(
  parameter int FLIT_WIDTH     = 16,
  parameter int MAX_CREDITS    = 3,
  parameter int BUFF_DEPTH     = 2,
  parameter int DST_PNT        = 4,
  parameter int DST_ADDR_WIDTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FLIT_WIDTH-3:0]              pkt_data,
  input  logic [DST_ADDR_WIDTH-1:0]          pkt_dst,
  input  logic                               pkt_last,
  input  logic                               pkt_valid,
  output logic                               pkt_ready,
  output logic [FLIT_WIDTH-1:0]              data_out,
  output logic                               valid_out,
  input  logic                               front_notify,
  output logic [$clog2(MAX_CREDITS+1)-1:0]   credits_avail,
  output logic                               err_credit_ovf
);

  localparam int CRED_W = $clog2(MAX_CREDITS + 1);
  localparam int CNT_W  = $clog2(BUFF_DEPTH + 1);
  localparam int PTR_W  = (BUFF_DEPTH > 1) ? $clog2(BUFF_DEPTH) : 1;

  typedef enum logic {IDLE, IN_PKT} pktState_e;

  pktState_e                 pktState_q, pktState_d;
  logic [FLIT_WIDTH-1:0]     fifoMem_q [BUFF_DEPTH];
  logic [PTR_W-1:0]          wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]          rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [CRED_W-1:0]         credit_q, credit_d;
  logic [FLIT_WIDTH-1:0]     dataOut_q, dataOut_d;
  logic                      validOut_q;

  logic [1:0]                flitType;
  logic [FLIT_WIDTH-3:0]     flitPayload;
  logic [FLIT_WIDTH-1:0]     flitWord;
  logic                      fifoEmpty, fifoFull;
  logic                      push, pop, memWrite, memRead;
  logic                      overflowEvt;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(BUFF_DEPTH - 1)) return '0;
    return ptr + PTR_W'(1);
  endfunction

  // Packet FSM state register, advanced only by accepted beats
  always_ff @(posedge clk) begin
    if (rst) pktState_q <= IDLE;
    else     pktState_q <= pktState_d;
  end

  // Packet FSM next state: a non-last head opens a packet, a tail closes it
  always_comb begin
    pktState_d = pktState_q;
    if (push) begin
      case (pktState_q)
        IDLE:    if (!pkt_last) pktState_d = IN_PKT;
        IN_PKT:  if (pkt_last)  pktState_d = IDLE;
        default: pktState_d = IDLE;
      endcase
    end
  end

  // Packet FSM outputs: flit type and destination insertion for the offered beat
  always_comb begin
    flitType    = 2'b00;
    flitPayload = pkt_data;
    case (pktState_q)
      IDLE: begin
        flitType = pkt_last ? 2'b11 : 2'b01;
        flitPayload[DST_PNT +: DST_ADDR_WIDTH] = pkt_dst;
      end
      IN_PKT:  flitType = pkt_last ? 2'b10 : 2'b00;
      default: flitType = 2'b00;
    endcase
    flitWord = {flitType, flitPayload};
  end

  // FIFO, send and credit bookkeeping; an empty FIFO forwards the incoming beat
  always_comb begin
    fifoEmpty   = (count_q == '0);
    fifoFull    = (count_q == CNT_W'(BUFF_DEPTH));
    push        = pkt_valid && !fifoFull;
    pop         = (credit_q != '0) && (!fifoEmpty || push);
    memWrite    = push && !(pop && fifoEmpty);
    memRead     = pop && !fifoEmpty;
    overflowEvt = front_notify && !pop && (credit_q == CRED_W'(MAX_CREDITS));

    wrPtr_d = memWrite ? nextPtr(wrPtr_q) : wrPtr_q;
    rdPtr_d = memRead  ? nextPtr(rdPtr_q) : rdPtr_q;

    count_d = count_q;
    if (memWrite && !memRead)      count_d = count_q + CNT_W'(1);
    else if (!memWrite && memRead) count_d = count_q - CNT_W'(1);

    credit_d = credit_q;
    if (front_notify && !pop && !overflowEvt) credit_d = credit_q + CRED_W'(1);
    else if (!front_notify && pop)            credit_d = credit_q - CRED_W'(1);

    dataOut_d = dataOut_q;
    if (pop) dataOut_d = fifoEmpty ? flitWord : fifoMem_q[rdPtr_q];
  end

  // Control and link registers; reset drops buffered flits and refills credits
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      credit_q   <= CRED_W'(MAX_CREDITS);
      dataOut_q  <= '0;
      validOut_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
      dataOut_q  <= dataOut_d;
      validOut_q <= pop;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (memWrite) fifoMem_q[wrPtr_q] <= flitWord;
  end

`ifdef NI_INJ_CREDIT_ERR_EN
  logic errOvf_q;

  // Sticky record of a credit returned while the count was already full
  always_ff @(posedge clk) begin
    if (rst)              errOvf_q <= 1'b0;
    else if (overflowEvt) errOvf_q <= 1'b1;
  end

  assign err_credit_ovf = errOvf_q;
`else
  assign err_credit_ovf = 1'b0;
`endif

  assign pkt_ready     = !fifoFull;
  assign data_out      = dataOut_q;
  assign valid_out     = validOut_q;
  assign credits_avail = credit_q;

endmodule

// File: tb/tb_ni_flit_injector.sv
// tb_ni_flit_injector: directed scenarios with literal expectations followed
// by randomized traffic, all checked every cycle against a queue-based model
// of the injector. Define NI_INJ_CREDIT_ERR_EN to exercise the sticky flag.
module tb_ni_flit_injector;

  localparam int FLIT_WIDTH     = 16;
  localparam int MAX_CREDITS    = 3;
  localparam int BUFF_DEPTH     = 2;
  localparam int DST_PNT        = 4;
  localparam int DST_ADDR_WIDTH = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [FLIT_WIDTH-3:0]     pktData = '0;
  logic [DST_ADDR_WIDTH-1:0] pktDst = '0;
  logic                      pktLast = 1'b0;
  logic                      pktValid = 1'b0;
  logic                      pktReady;
  logic [FLIT_WIDTH-1:0]     dataOut;
  logic                      validOut;
  logic                      frontNotify = 1'b0;
  logic [1:0]                creditsAvail;
  logic                      errCreditOvf;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 0;

  logic [FLIT_WIDTH-1:0] mq[$];
  int                    mCred = MAX_CREDITS;
  bit                    mInPkt = 0;
  bit                    mExpValid = 0;
  logic [FLIT_WIDTH-1:0] mExpData = '0;
  bit                    mOvf = 0;

  ni_flit_injector #(
    .FLIT_WIDTH(FLIT_WIDTH), .MAX_CREDITS(MAX_CREDITS), .BUFF_DEPTH(BUFF_DEPTH),
    .DST_PNT(DST_PNT), .DST_ADDR_WIDTH(DST_ADDR_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .pkt_data(pktData), .pkt_dst(pktDst),
    .pkt_last(pktLast), .pkt_valid(pktValid), .pkt_ready(pktReady),
    .data_out(dataOut), .valid_out(validOut), .front_notify(frontNotify),
    .credits_avail(creditsAvail), .err_credit_ovf(errCreditOvf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats join a queue, the front leaves whenever a credit exists
  always @(posedge clk) begin
    bit                    accept, sent;
    logic [1:0]            ftype;
    logic [FLIT_WIDTH-3:0] pay;
    if (rst) begin
      mq.delete();
      mCred = MAX_CREDITS;
      mInPkt = 0;
      mExpValid = 0;
      mExpData = '0;
      mOvf = 0;
    end else begin
      accept = pktValid && (mq.size() < BUFF_DEPTH);
      if (accept) begin
        pay = pktData;
        if (!mInPkt) begin
          pay[DST_PNT +: DST_ADDR_WIDTH] = pktDst;
          ftype = pktLast ? 2'b11 : 2'b01;
        end else begin
          ftype = pktLast ? 2'b10 : 2'b00;
        end
        mInPkt = !pktLast;
        mq.push_back({ftype, pay});
      end
      sent = (mq.size() > 0) && (mCred > 0);
      if (sent) mExpData = mq.pop_front();
      mExpValid = sent;
      if (frontNotify && !sent) begin
        if (mCred == MAX_CREDITS) mOvf = 1;
        else mCred++;
      end else if (sent && !frontNotify) begin
        mCred--;
      end
    end
  end

  // Compare every registered output with the model between edges
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("valid_out", 32'(validOut), 32'(mExpValid));
      checkOutput("data_out", 32'(dataOut), 32'(mExpData));
      checkOutput("credits_avail", 32'(creditsAvail), 32'(mCred));
      checkOutput("pkt_ready", 32'(pktReady), 32'(mq.size() < BUFF_DEPTH));
`ifdef NI_INJ_CREDIT_ERR_EN
      checkOutput("err_credit_ovf", 32'(errCreditOvf), 32'(mOvf));
`else
      checkOutput("err_credit_ovf", 32'(errCreditOvf), 32'd0);
`endif
    end
  end

  task automatic applyStimulus(input bit v, input logic [FLIT_WIDTH-3:0] d,
                               input logic [DST_ADDR_WIDTH-1:0] dst, input bit last,
                               input bit notify);
    pktValid    = v;
    pktData     = d;
    pktDst      = dst;
    pktLast     = last;
    frontNotify = notify;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset(input int cycles);
    pktValid    = 0;
    frontNotify = 0;
    rst         = 1;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 0;
  endtask

  initial begin
    doReset(2);
    checkEn = 1;
    checkOutput("rst valid_out", 32'(validOut), 32'd0);
    checkOutput("rst data_out", 32'(dataOut), 32'd0);
    checkOutput("rst credits", 32'(creditsAvail), 32'd3);
    checkOutput("rst pkt_ready", 32'(pktReady), 32'd1);
    checkOutput("rst err", 32'(errCreditOvf), 32'd0);

    // Single beat goes straight out with its destination inserted
    applyStimulus(1, 14'h0ABC, 2'd2, 1, 0);
    checkOutput("single valid", 32'(validOut), 32'd1);
    checkOutput("single data", 32'(dataOut), 32'hCAAC);
    checkOutput("single credits", 32'(creditsAvail), 32'd2);
    applyStimulus(0, '0, '0, 0, 1);
    checkOutput("notify credits", 32'(creditsAvail), 32'd3);

    // Four-beat packet with no credit returns: tail waits in the FIFO
    applyStimulus(1, 14'h0001, 2'd1, 0, 0);
    checkOutput("pkt head data", 32'(dataOut), 32'h4011);
    applyStimulus(1, 14'h0002, 2'd1, 0, 0);
    checkOutput("pkt body1 type", 32'(dataOut[15:14]), 32'd0);
    applyStimulus(1, 14'h0003, 2'd1, 0, 0);
    checkOutput("pkt body2 type", 32'(dataOut[15:14]), 32'd0);
    checkOutput("pkt credits0", 32'(creditsAvail), 32'd0);
    applyStimulus(1, 14'h0004, 2'd1, 1, 0);
    checkOutput("pkt tail held", 32'(validOut), 32'd0);
    applyStimulus(0, '0, '0, 0, 1);
    checkOutput("pkt credit back", 32'(creditsAvail), 32'd1);
    applyStimulus(0, '0, '0, 0, 0);
    checkOutput("pkt tail valid", 32'(validOut), 32'd1);
    checkOutput("pkt tail data", 32'(dataOut), 32'h8004);
    checkOutput("pkt tail credits", 32'(creditsAvail), 32'd0);

    // Send and credit return in the same cycle keep the count
    applyStimulus(0, '0, '0, 0, 1);
    applyStimulus(1, 14'h0123, 2'd0, 1, 1);
    checkOutput("sendnotify credits", 32'(creditsAvail), 32'd1);
    applyStimulus(1, 14'h0456, 2'd0, 1, 0);
    checkOutput("second send valid", 32'(validOut), 32'd1);
    checkOutput("second send credits", 32'(creditsAvail), 32'd0);
    repeat (3) applyStimulus(0, '0, '0, 0, 1);

    // Credit return at full count saturates
    applyStimulus(0, '0, '0, 0, 1);
    checkOutput("ovf credits", 32'(creditsAvail), 32'd3);
    applyStimulus(0, '0, '0, 0, 0);
`ifdef NI_INJ_CREDIT_ERR_EN
    checkOutput("ovf sticky", 32'(errCreditOvf), 32'd1);
`else
    checkOutput("ovf tied", 32'(errCreditOvf), 32'd0);
`endif

    // Drain credits, then fill the FIFO and release it one credit at a time
    repeat (3) applyStimulus(1, 14'h0100, 2'd0, 1, 0);
    applyStimulus(1, 14'h0AAA, 2'd0, 1, 0);
    applyStimulus(1, 14'h0BBB, 2'd0, 1, 0);
    checkOutput("full ready", 32'(pktReady), 32'd0);
    applyStimulus(1, 14'h0CCC, 2'd0, 1, 1);
    applyStimulus(1, 14'h0CCC, 2'd0, 1, 0);
    checkOutput("full pop data", 32'(dataOut), 32'hCA8A);
    applyStimulus(1, 14'h0CCC, 2'd0, 1, 1);
    applyStimulus(0, '0, '0, 0, 0);
    checkOutput("order second", 32'(dataOut), 32'hCB8B);
    repeat (5) applyStimulus(0, '0, '0, 0, 1);

    // Reset in the middle of a packet restarts at a head
    applyStimulus(1, 14'h0111, 2'd1, 0, 0);
    doReset(1);
    checkOutput("midrst valid", 32'(validOut), 32'd0);
    checkOutput("midrst credits", 32'(creditsAvail), 32'd3);
    applyStimulus(1, 14'h0000, 2'd3, 1, 0);
    checkOutput("after rst single", 32'(dataOut), 32'hC030);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset(1);
      end else begin
        applyStimulus($urandom_range(0, 9) < 7, 14'($urandom_range(0, 16383)),
                      2'($urandom_range(0, 3)), $urandom_range(0, 9) < 3,
                      $urandom_range(0, 9) < 4);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
